// File: rtl/lc3b_pkg.sv
// Shared types and helpers for the datapath bus arbiter/multiplexer.
package lc3b_pkg;

  // Arbiter FSM encoding.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    if (value > 1) begin
      for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
        result++;
      end
    end
    return result;
  endfunction

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Combinational winner picker: round-robin from ptr, or fixed priority from index 0.
module rr_pick
  import lc3b_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             rr,
  output logic [N-1:0]     win,
  output logic [SEL_W-1:0] index
);

  logic        found;
  int unsigned start;

  // Two passes give an upward search from start with wrap, without a modulo.
  always_comb begin
    win   = '0;
    index = '0;
    found = 1'b0;
    start = rr ? 32'(ptr) : 32'd0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= start)) begin
        found  = 1'b1;
        win[i] = 1'b1;
        index  = SEL_W'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (i < start)) begin
        found  = 1'b1;
        win[i] = 1'b1;
        index  = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// Registered N-way word multiplexer with internal arbitration and multi-word bus ownership.
module arb_mux
  import lc3b_pkg::*;
#(
  parameter int unsigned  WIDTH = 16,
  parameter int unsigned  N     = 3,
  parameter int unsigned  RR    = 1,
  localparam int unsigned SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic [N-1:0]       gnt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_last,
  input  logic               out_ready
);

  state_e             state_q;
  logic [N-1:0]       gnt_q;
  logic [SEL_W-1:0]   owner_q;
  logic [SEL_W-1:0]   rr_ptr_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;
  logic [SEL_W-1:0]   out_sel_q;
  logic               out_last_q;

  logic               space;
  logic               accept;
  logic [N-1:0]       win;
  logic [SEL_W-1:0]   win_idx;
  logic [WIDTH-1:0]   sel_data;
  logic               sel_last;
  logic [SEL_W-1:0]   rr_next;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .rr    (RR != 0),
    .win   (win),
    .index (win_idx)
  );

  // Handshake: only the owner sees ready, and only when the output slot can take a word.
  always_comb begin
    space    = !out_valid_q | out_ready;
    in_ready = gnt_q & {N{space}};
    accept   = |(req & in_ready);
  end

  // Owner's word and last flag, selected by the one-hot grant.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_q[i]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_last = in_last[i];
      end
    end
  end

  // Round-robin pointer for the channel after the current owner.
  always_comb begin
    if (32'(owner_q) == N - 1) begin
      rr_next = '0;
    end else begin
      rr_next = owner_q + 1'b1;
    end
  end

  // Arbitration FSM, grant, round-robin pointer and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|req) begin
            gnt_q   <= win;
            owner_q <= win_idx;
            state_q <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          // Ownership persists across req gaps until the last word is accepted.
          if (accept && sel_last) begin
            gnt_q   <= '0;
            state_q <= ST_IDLE;
            if (RR != 0) begin
              rr_ptr_q <= rr_next;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase

      out_valid_q <= accept | (out_valid_q & !out_ready);
      if (accept) begin
        out_data_q <= sel_data;
        out_sel_q  <= owner_q;
        out_last_q <= sel_last;
      end
    end
  end

  assign gnt       = gnt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: round-robin and fixed-priority instances share stimulus.
module tb_arb_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [47:0] in_data = '0;
  logic [2:0]  in_last = '0;
  logic        out_ready = 1'b1;

  logic [2:0]  rr_in_ready, rr_gnt, fp_in_ready, fp_gnt;
  logic        rr_out_valid, rr_out_last, fp_out_valid, fp_out_last;
  logic [15:0] rr_out_data, fp_out_data;
  logic [1:0]  rr_out_sel, fp_out_sel;

  logic        use_fp = 1'b0;
  logic [2:0]  obs_in_ready, obs_gnt;
  logic        obs_valid, obs_last;
  logic [15:0] obs_data;
  logic [1:0]  obs_sel;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(16), .N(3), .RR(1)) dut_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (rr_in_ready),
    .gnt       (rr_gnt),
    .out_valid (rr_out_valid),
    .out_data  (rr_out_data),
    .out_sel   (rr_out_sel),
    .out_last  (rr_out_last),
    .out_ready (out_ready)
  );

  arb_mux #(.WIDTH(16), .N(3), .RR(0)) dut_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (fp_in_ready),
    .gnt       (fp_gnt),
    .out_valid (fp_out_valid),
    .out_data  (fp_out_data),
    .out_sel   (fp_out_sel),
    .out_last  (fp_out_last),
    .out_ready (out_ready)
  );

  assign obs_in_ready = use_fp ? fp_in_ready  : rr_in_ready;
  assign obs_gnt      = use_fp ? fp_gnt       : rr_gnt;
  assign obs_valid    = use_fp ? fp_out_valid : rr_out_valid;
  assign obs_data     = use_fp ? fp_out_data  : rr_out_data;
  assign obs_sel      = use_fp ? fp_out_sel   : rr_out_sel;
  assign obs_last     = use_fp ? fp_out_last  : rr_out_last;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] data;
    logic        last;
  } word_t;

  word_t       sb[$];
  int          seen_sel[$];
  logic [15:0] seen_data[$];

  bit          m_owned, m_valid, m_acc;
  int          m_owner, m_ptr, m_acc_ch;
  logic [2:0]  m_gnt;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int pick(input logic [2:0] r, input int start);
    for (int k = 0; k < 3; k++) begin
      if (r[(start + k) % 3]) return (start + k) % 3;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_owned = 0; m_valid = 0; m_owner = 0; m_ptr = 0; m_gnt = '0; m_acc = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; in_last = '0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock with the current inputs: check registered state, score output, advance the model.
  task automatic cycle();
    logic [2:0] exp_ir;
    bit         sp, nv;
    word_t      w, e;
    #1;
    n_tests++;
    if (obs_gnt !== m_gnt) begin
      n_fail++; $display("FAIL gnt: got %b expected %b", obs_gnt, m_gnt);
    end
    n_tests++;
    if (obs_valid !== m_valid) begin
      n_fail++; $display("FAIL out_valid: got %b expected %b", obs_valid, m_valid);
    end
    sp     = !m_valid || out_ready;
    exp_ir = (m_owned && sp) ? m_gnt : 3'b000;
    n_tests++;
    if (obs_in_ready !== exp_ir) begin
      n_fail++; $display("FAIL in_ready: got %b expected %b", obs_in_ready, exp_ir);
    end
    if (obs_valid && out_ready) begin
      seen_sel.push_back(int'(obs_sel));
      seen_data.push_back(obs_data);
    end
    if (m_valid && out_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL scoreboard: got word %h expected none", obs_data);
      end else begin
        e = sb.pop_front();
        if (obs_sel !== e.sel || obs_data !== e.data || obs_last !== e.last) begin
          n_fail++;
          $display("FAIL out_word: got sel=%0d data=%h last=%b expected sel=%0d data=%h last=%b",
                   obs_sel, obs_data, obs_last, e.sel, e.data, e.last);
        end
      end
    end
    m_acc = m_owned && req[m_owner] && sp;
    m_acc_ch = m_owner;
    if (m_acc) begin
      w.sel  = 2'(m_owner);
      w.data = in_data[m_owner*16 +: 16];
      w.last = in_last[m_owner];
      sb.push_back(w);
    end
    nv = m_acc || (m_valid && !out_ready);
    if (!m_owned) begin
      if (|req) begin
        m_owner = pick(req, use_fp ? 0 : m_ptr);
        m_owned = 1;
        m_gnt   = 3'b001 << m_owner;
      end
    end else if (m_acc && in_last[m_owner]) begin
      m_owned = 0;
      m_gnt   = '0;
      if (!use_fp) m_ptr = (m_owner + 1) % 3;
    end
    m_valid = nv;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 3'b111; in_last = 3'b111; out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (obs_gnt !== 3'b000 || obs_valid !== 1'b0 || obs_data !== 16'h0 || obs_sel !== 2'd0 ||
        obs_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got gnt=%b valid=%b data=%h sel=%0d last=%b expected all 0",
               obs_gnt, obs_valid, obs_data, obs_sel, obs_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    #1;
    n_tests++;
    if (obs_gnt !== 3'b001) begin
      n_fail++; $display("FAIL reset_first_gnt: got %b expected 001", obs_gnt);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 3; i++) in_data[i*16 +: 16] = 16'hA000 + 16'(i);
    req = 3'b111; in_last = 3'b111; out_ready = 1'b1;
    seen_sel.delete(); seen_data.delete();
    repeat (9) cycle();
    n_tests++;
    if (seen_sel.size() != 4) begin
      n_fail++; $display("FAIL rr_word_count: got %0d expected 4", seen_sel.size());
    end else begin
      n_tests++;
      if (seen_sel[0] != 0 || seen_sel[1] != 1 || seen_sel[2] != 2 || seen_sel[3] != 0) begin
        n_fail++;
        $display("FAIL rr_order: got %0d,%0d,%0d,%0d expected 0,1,2,0",
                 seen_sel[0], seen_sel[1], seen_sel[2], seen_sel[3]);
      end
    end
  endtask

  task automatic test_multi_word();
    int k;
    do_reset();
    in_data = {16'h0C0C, 16'h1111, 16'h0A0A};
    in_last = 3'b101; out_ready = 1'b1; req = 3'b010;
    seen_sel.delete(); seen_data.delete();
    k = 0;
    cycle();
    req = 3'b111;
    for (int t = 0; t < 20 && k < 4; t++) begin
      cycle();
      if (m_acc && m_acc_ch == 1) begin
        k++;
        in_data[31:16] = 16'(32'h1111 * (k + 1));
        in_last[1] = (k == 3);
      end
    end
    n_tests++;
    if (k != 4) begin
      n_fail++; $display("FAIL mw_timeout: got %0d words expected 4", k);
    end
    cycle();
    #1;
    n_tests++;
    if (obs_gnt !== 3'b100) begin
      n_fail++; $display("FAIL mw_next_owner: got %b expected 100", obs_gnt);
    end
    repeat (2) cycle();
    n_tests++;
    if (seen_data.size() < 4) begin
      n_fail++; $display("FAIL mw_count: got %0d expected >=4", seen_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (seen_data[i] !== 16'(32'h1111 * (i + 1)) || seen_sel[i] != 1) begin
          n_fail++;
          $display("FAIL mw_word%0d: got sel=%0d data=%h expected sel=1 data=%h",
                   i, seen_sel[i], seen_data[i], 16'(32'h1111 * (i + 1)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] words[3];
    int k;
    words[0] = 16'hA001; words[1] = 16'hA002; words[2] = 16'hA003;
    do_reset();
    seen_sel.delete(); seen_data.delete();
    req = 3'b001; in_last = 3'b000; out_ready = 1'b1;
    in_data[15:0] = words[0];
    k = 0;
    cycle();
    cycle();
    k = 1; in_data[15:0] = words[1];
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      n_tests++;
      if (obs_valid !== 1'b1 || obs_data !== words[0] || obs_in_ready !== 3'b000) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got valid=%b data=%h in_ready=%b expected 1 %h 000",
                 s, obs_valid, obs_data, obs_in_ready, words[0]);
      end
      cycle();
    end
    out_ready = 1'b1;
    for (int t = 0; t < 10 && k < 3; t++) begin
      cycle();
      if (m_acc) begin
        k++;
        if (k < 3) begin
          in_data[15:0] = words[k];
          in_last[0] = (k == 2);
        end else begin
          req = 3'b000;
        end
      end
    end
    req = 3'b000;
    repeat (3) cycle();
    n_tests++;
    if (seen_data.size() != 3) begin
      n_fail++; $display("FAIL bp_count: got %0d expected 3", seen_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (seen_data[i] !== words[i]) begin
          n_fail++; $display("FAIL bp_word%0d: got %h expected %h", i, seen_data[i], words[i]);
        end
      end
    end
  endtask

  task automatic test_fixed_priority();
    int exp_sel[5];
    exp_sel[0] = 1; exp_sel[1] = 0; exp_sel[2] = 0; exp_sel[3] = 0; exp_sel[4] = 2;
    use_fp = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) in_data[i*16 +: 16] = 16'hF000 + 16'(i);
    in_last = 3'b111; out_ready = 1'b1;
    seen_sel.delete(); seen_data.delete();
    req = 3'b110;
    cycle();
    req = 3'b111;
    repeat (7) cycle();
    req = 3'b100;
    repeat (2) cycle();
    req = 3'b000;
    repeat (2) cycle();
    n_tests++;
    if (seen_sel.size() != 5) begin
      n_fail++; $display("FAIL fp_count: got %0d expected 5", seen_sel.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (seen_sel[i] != exp_sel[i]) begin
          n_fail++; $display("FAIL fp_sel%0d: got %0d expected %0d", i, seen_sel[i], exp_sel[i]);
        end
      end
    end
    use_fp = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) in_data[i*16 +: 16] = 16'hB000 + 16'(i);
    out_ready = 1'b1;
    req = 3'b001; in_last = 3'b111;
    cycle();
    cycle();
    req = 3'b010; in_last = 3'b000;
    cycle();
    cycle();
    #1;
    n_tests++;
    if (obs_gnt !== 3'b010 || obs_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_pre: got gnt=%b valid=%b expected 010 1", obs_gnt, obs_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs_gnt !== 3'b000 || obs_valid !== 1'b0 || obs_data !== 16'h0 || obs_sel !== 2'd0 ||
        obs_last !== 1'b0 || obs_in_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL ar_clear: got gnt=%b valid=%b data=%h sel=%0d last=%b ir=%b expected 0",
               obs_gnt, obs_valid, obs_data, obs_sel, obs_last, obs_in_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req = 3'b111; in_last = 3'b111;
    cycle();
    #1;
    n_tests++;
    if (obs_gnt !== 3'b001) begin
      n_fail++; $display("FAIL ar_restart: got %b expected 001", obs_gnt);
    end
    repeat (2) cycle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_multi_word();
    test_backpressure();
    test_fixed_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
